// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB master port between NREQ requesters
module apb_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int dataWidth = 32,
    parameter int addrWidth = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_write,
    input  logic [NREQ*addrWidth-1:0]   req_addr,
    input  logic [NREQ*dataWidth-1:0]   req_wdata,
    input  logic [NREQ*dataWidth/8-1:0] req_strb,
    input  logic [NREQ*3-1:0]           req_prot,
    output logic [NREQ-1:0]             req_done,
    output logic [NREQ-1:0]             gnt,
    output logic [dataWidth-1:0]        rsp_rdata,
    output logic                        rsp_slverr,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [addrWidth-1:0]        paddr,
    output logic [dataWidth-1:0]        pwdata,
    output logic [dataWidth/8-1:0]      pstrb,
    output logic [2:0]                  pprot,
    input  logic                        pready,
    input  logic [dataWidth-1:0]        prdata,
    input  logic                        pslverr
);
    localparam int IW = $clog2(NREQ);
    localparam int SW = dataWidth / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [NREQ-1:0]      done_q, done_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [addrWidth-1:0] paddr_q, paddr_d;
    logic [dataWidth-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]        pstrb_q, pstrb_d;
    logic [2:0]           pprot_q, pprot_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;
    logic                 slverr_q, slverr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [NREQ-1:0]      cand;
    logic [IW-1:0]        base;
    logic [IW-1:0]        win;
    logic                 found;
    logic                 launch;
    logic                 end_xfer;
    logic                 timeout;
    int                   idx;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        cnt_d     = cnt_q;
        cand      = req_valid;
        base      = ptr_q;
        launch    = 1'b0;
        end_xfer  = 1'b0;
        timeout   = 1'b0;
        found     = 1'b0;
        win       = '0;
        idx       = 0;

        case (state_q)
            IDLE: launch = |req_valid;
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready) begin
                    end_xfer = 1'b1;
                end else if (TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    end_xfer = 1'b1;
                    timeout  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (end_xfer) begin
                    done_d = gnt_q;
                    ptr_d  = gidx_q;
                    if (timeout) begin
                        rdata_d  = '0;
                        slverr_d = 1'b1;
                    end else begin
                        if (!pwrite_q) rdata_d = prdata;
                        slverr_d = pslverr;
                    end
                    // The finishing requester still holds valid this cycle; exclude it.
                    cand   = req_valid & ~gnt_q;
                    base   = gidx_q;
                    launch = |cand;
                    if (!launch) begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        gnt_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(base) + k) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end

        if (launch) begin
            state_d      = SETUP;
            psel_d       = 1'b1;
            penable_d    = 1'b0;
            gidx_d       = win;
            gnt_d        = '0;
            gnt_d[win]   = 1'b1;
            pwrite_d     = req_write[win];
            paddr_d      = req_addr[win*addrWidth +: addrWidth];
            pwdata_d     = req_wdata[win*dataWidth +: dataWidth];
            pstrb_d      = req_strb[win*SW +: SW];
            pprot_d      = req_prot[win*3 +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(NREQ - 1);
            gidx_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_done   = done_q;
    assign gnt        = gnt_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_slverr = slverr_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign pprot      = pprot_q;
endmodule
